// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared definitions for the ROB allocation/recovery controller.
package rob_alloc_ctrl_pkg;

    localparam int unsigned ROB_NUM_DEF     = 64;
    localparam int unsigned ROB_SEL_DEF     = 6;
    localparam int unsigned RECOVER_CYC_DEF = 2;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // Distance a - b modulo 2^w (w <= 31).
    function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/rob_alloc_ctrl.sv
// Two-wide ROB allocation controller: tail/head pointers, grants and mispredict rewind.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int unsigned ROB_NUM     = ROB_NUM_DEF,
    parameter int unsigned ROB_SEL     = ROB_SEL_DEF,
    parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic [1:0]         comnum_i,
    input  logic               prmiss_i,
    input  logic [ROB_SEL-1:0] prmiss_addr_i,
    output logic               dp1_o,
    output logic               dp2_o,
    output logic [ROB_SEL-1:0] dp1_addr_o,
    output logic [ROB_SEL-1:0] dp2_addr_o,
    output logic [ROB_SEL-1:0] dispatch_ptr_o,
    output logic [ROB_SEL:0]   freenum_o,
    output logic               stall_o,
    output logic               recovering_o
);

    localparam int unsigned PW = ROB_SEL + 1;
    localparam int unsigned CW = 4;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [PW-1:0]     dptr, dptr_nxt;
    logic [PW-1:0]     cptr, cptr_nxt;
    logic [PW-1:0]     occ;
    logic [ROB_SEL-1:0] off;

    assign occ       = PW'(ptr_dist(32'(dptr), 32'(cptr), PW));
    assign freenum_o = PW'(ROB_NUM) - occ;

    // Grants depend on this cycle's requests and the registered pointers only.
    assign dp1_o          = req1_i & (state == RUN) & ~prmiss_i & (freenum_o >= PW'(1));
    assign dp2_o          = req2_i & dp1_o & (freenum_o >= PW'(2));
    assign dp1_addr_o     = dptr[ROB_SEL-1:0];
    assign dp2_addr_o     = ROB_SEL'(dptr + PW'(1));
    assign dispatch_ptr_o = dptr[ROB_SEL-1:0];
    assign stall_o        = (req1_i & ~dp1_o) | (req2_i & ~dp2_o);
    assign recovering_o   = (state == RECOVER);

    // Next-state, pointer update and rewind arithmetic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cptr_nxt  = cptr + PW'(comnum_i);
        dptr_nxt  = dptr + PW'(dp1_o) + PW'(dp2_o);
        off       = ROB_SEL'(ptr_dist(32'(prmiss_addr_i), 32'(cptr[ROB_SEL-1:0]), ROB_SEL));
        if (prmiss_i) begin
            // Offset is taken from the pre-commit head so the wrap bit stays right.
            dptr_nxt  = cptr + PW'(off) + PW'(1);
            state_nxt = RECOVER;
            cnt_nxt   = CW'(RECOVER_CYC - 1);
        end else if (state == RECOVER) begin
            if (cnt == '0) begin
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            dptr  <= '0;
            cptr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dptr  <= dptr_nxt;
            cptr  <= cptr_nxt;
        end
    end

    // Protocol checks on the ROB interface.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (PW'(comnum_i) <= occ)
                else $error("rob_alloc_ctrl: comnum_i exceeds occupancy");
            if (prmiss_i) begin
                assert (PW'(off) < occ)
                    else $error("rob_alloc_ctrl: prmiss_addr_i not an occupied entry");
            end
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Vector-table bench for rob_alloc_ctrl with an expected-value queue.
module tb_rob_alloc_ctrl;

    logic       clk;
    logic       reset;
    logic       req1_i, req2_i, prmiss_i;
    logic [1:0] comnum_i;
    logic [5:0] prmiss_addr_i;
    logic       dp1_o, dp2_o, stall_o, recovering_o;
    logic [5:0] dp1_addr_o, dp2_addr_o, dispatch_ptr_o;
    logic [6:0] freenum_o;

    rob_alloc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req1_i         (req1_i),
        .req2_i         (req2_i),
        .comnum_i       (comnum_i),
        .prmiss_i       (prmiss_i),
        .prmiss_addr_i  (prmiss_addr_i),
        .dp1_o          (dp1_o),
        .dp2_o          (dp2_o),
        .dp1_addr_o     (dp1_addr_o),
        .dp2_addr_o     (dp2_addr_o),
        .dispatch_ptr_o (dispatch_ptr_o),
        .freenum_o      (freenum_o),
        .stall_o        (stall_o),
        .recovering_o   (recovering_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       r1;
        logic       r2;
        logic [1:0] cn;
        logic       pm;
        logic [5:0] pa;
        logic       chk;
        logic       dp1;
        logic       dp2;
        logic [5:0] a1;
        logic [5:0] a2;
        logic [5:0] dptr;
        logic [6:0] free;
        logic       stall;
        logic       rec;
    } vec_t;

    vec_t tbl[256];
    vec_t exp_q[$];
    int   n_vec;
    int   n_chk;
    int   n_fail;

    task automatic add(input int rst, input int r1, input int r2, input int cn,
                       input int pm, input int pa, input int chk,
                       input int dp1, input int dp2, input int a1, input int a2,
                       input int dptr, input int free, input int stall, input int rec);
        vec_t v;
        v.rst = 1'(rst);  v.r1 = 1'(r1);  v.r2 = 1'(r2);  v.cn = 2'(cn);
        v.pm = 1'(pm);    v.pa = 6'(pa);  v.chk = 1'(chk);
        v.dp1 = 1'(dp1);  v.dp2 = 1'(dp2); v.a1 = 6'(a1); v.a2 = 6'(a2);
        v.dptr = 6'(dptr); v.free = 7'(free); v.stall = 1'(stall); v.rec = 1'(rec);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    task automatic check(input string name, input int idx, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, expv);
        end
    endtask

    initial begin
        vec_t e;
        n_vec = 0; n_chk = 0; n_fail = 0;
        reset = 1'b1; req1_i = 1'b0; req2_i = 1'b0; comnum_i = 2'd0;
        prmiss_i = 1'b0; prmiss_addr_i = 6'd0;

        // Reset values, lone req2
        add(1,0,0,0,0,0, 0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0, 1, 0,0,0,1,0,64,0,0);
        add(0,0,1,0,0,0, 1, 0,0,0,1,0,64,1,0);
        // Fill the ROB with double grants
        for (int i = 0; i < 32; i++)
            add(0,1,1,0,0,0, 1, 1,1,2*i,2*i+1,2*i,64-2*i,0,0);
        add(0,1,1,0,0,0, 1, 0,0,0,1,0,0,1,0);
        // One commit frees exactly one entry, visible a cycle later
        add(0,0,0,1,0,0, 1, 0,0,0,1,0,0,0,0);
        add(0,1,1,0,0,0, 1, 1,0,0,1,0,1,1,0);
        add(0,0,0,0,0,0, 1, 0,0,1,2,1,0,0,0);
        // Tail wrap with steady commits
        add(1,0,0,0,0,0, 0, 0,0,0,0,0,0,0,0);
        for (int i = 0; i < 32; i++)
            add(0,1,1,(i > 0) ? 2 : 0,0,0, 1, 1,1,2*i,2*i+1,2*i,(i == 0) ? 64 : 62,0,0);
        add(0,0,0,2,0,0, 1, 0,0,0,1,0,62,0,0);
        add(0,0,0,0,0,0, 1, 0,0,0,1,0,64,0,0);
        // Mispredict at 3 with occupancy 10
        add(1,0,0,0,0,0, 0, 0,0,0,0,0,0,0,0);
        for (int i = 0; i < 5; i++)
            add(0,1,1,0,0,0, 1, 1,1,2*i,2*i+1,2*i,64-2*i,0,0);
        add(0,1,1,0,1,3, 1, 0,0,10,11,10,54,1,0);
        add(0,1,1,0,0,0, 1, 0,0,4,5,4,60,1,1);
        add(0,1,1,0,0,0, 1, 0,0,4,5,4,60,1,1);
        add(0,1,1,0,0,0, 1, 1,1,4,5,4,60,0,0);
        // Mispredict with simultaneous commit of two
        add(0,0,0,2,0,0, 1, 0,0,6,7,6,58,0,0);
        add(0,0,0,2,0,0, 1, 0,0,6,7,6,60,0,0);
        add(0,0,0,2,1,5, 1, 0,0,6,7,6,62,0,0);
        add(0,0,0,0,0,0, 1, 0,0,6,7,6,64,0,1);
        add(0,0,0,0,0,0, 1, 0,0,6,7,6,64,0,1);
        add(0,0,0,0,0,0, 1, 0,0,6,7,6,64,0,0);
        // Mispredict inside RECOVER restarts the window
        add(0,1,0,0,0,0, 1, 1,0,6,7,6,64,0,0);
        add(0,0,0,0,1,6, 1, 0,0,7,8,7,63,0,0);
        add(0,0,0,0,1,6, 1, 0,0,7,8,7,63,0,1);
        add(0,0,0,0,0,0, 1, 0,0,7,8,7,63,0,1);
        add(0,0,0,0,0,0, 1, 0,0,7,8,7,63,0,1);
        add(0,1,0,0,0,0, 1, 1,0,7,8,7,63,0,0);
        // Reset during RECOVER
        add(0,0,0,0,1,7, 1, 0,0,8,9,8,62,0,0);
        add(1,1,0,0,0,0, 1, 0,0,8,9,8,62,1,1);
        add(0,1,0,0,0,0, 1, 1,0,0,1,0,64,0,0);
        add(0,0,0,0,0,0, 1, 0,0,1,2,1,63,0,0);

        for (int k = 0; k < n_vec; k++) begin
            @(negedge clk);
            reset = tbl[k].rst; req1_i = tbl[k].r1; req2_i = tbl[k].r2;
            comnum_i = tbl[k].cn; prmiss_i = tbl[k].pm; prmiss_addr_i = tbl[k].pa;
            exp_q.push_back(tbl[k]);
            #2;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("dp1",       k, int'(dp1_o),          int'(e.dp1));
                check("dp2",       k, int'(dp2_o),          int'(e.dp2));
                check("dp1_addr",  k, int'(dp1_addr_o),     int'(e.a1));
                check("dp2_addr",  k, int'(dp2_addr_o),     int'(e.a2));
                check("dptr",      k, int'(dispatch_ptr_o), int'(e.dptr));
                check("freenum",   k, int'(freenum_o),      int'(e.free));
                check("stall",     k, int'(stall_o),        int'(e.stall));
                check("recover",   k, int'(recovering_o),   int'(e.rec));
            end
        end
        @(negedge clk);
        reset = 1'b0; req1_i = 1'b0; req2_i = 1'b0; comnum_i = 2'd0; prmiss_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
